// File: rtl/seven_seg_pkg.sv
// Shared constants and types for seven-segment display blocks.
package seven_seg_pkg;

   // Bit positions inside an {dp,g,f,e,d,c,b,a} segment byte.
   localparam int unsigned SEG_A  = 0;
   localparam int unsigned SEG_B  = 1;
   localparam int unsigned SEG_C  = 2;
   localparam int unsigned SEG_D  = 3;
   localparam int unsigned SEG_E  = 4;
   localparam int unsigned SEG_F  = 5;
   localparam int unsigned SEG_G  = 6;
   localparam int unsigned SEG_DP = 7;

   // Widest digit bank any display block is expected to scan.
   localparam int unsigned MAX_DIGITS = 8;

   // Per-digit slot phases of the scan controller.
   typedef enum logic [0:0] {
      StBlank,
      StDrive
   } scan_state_e;

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to active-high {dp,g,f,e,d,c,b,a} pattern; dp (bit 7) is always 0.
module hex_to_7seg (
   input  logic [3:0] nibble_i,
   output logic [7:0] seg_o
);

   // Pure lookup, glyphs 0-9 and A b C d E F.
   always_comb begin
      seg_o = 8'h00;
      case (nibble_i)
         4'h0:    seg_o = 8'h3F;
         4'h1:    seg_o = 8'h06;
         4'h2:    seg_o = 8'h5B;
         4'h3:    seg_o = 8'h4F;
         4'h4:    seg_o = 8'h66;
         4'h5:    seg_o = 8'h6D;
         4'h6:    seg_o = 8'h7D;
         4'h7:    seg_o = 8'h07;
         4'h8:    seg_o = 8'h7F;
         4'h9:    seg_o = 8'h6F;
         4'hA:    seg_o = 8'h77;
         4'hB:    seg_o = 8'h7C;
         4'hC:    seg_o = 8'h39;
         4'hD:    seg_o = 8'h5E;
         4'hE:    seg_o = 8'h79;
         4'hF:    seg_o = 8'h71;
         default: seg_o = 8'h00;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a blanking gap per digit and
// frame-synchronous double buffering of host writes.
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS           = 4,
   parameter int unsigned CYCLES_PER_DIGIT     = 16000,
   parameter int unsigned BLANK_CYCLES         = 160,
   parameter bit          DIGIT_SEL_ACTIVE_LOW = 1'b1
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    i_wr_valid,
   output logic                    o_wr_ready,
   input  logic [4*NUM_DIGITS-1:0] i_wr_data,
   input  logic [NUM_DIGITS-1:0]   i_wr_dp,
   input  logic [NUM_DIGITS-1:0]   i_wr_blank,
   output logic [7:0]              o_seg,
   output logic [NUM_DIGITS-1:0]   o_digit_sel,
   output logic                    o_frame_start
);

   localparam int unsigned CntMax = (BLANK_CYCLES > CYCLES_PER_DIGIT) ? BLANK_CYCLES
                                                                      : CYCLES_PER_DIGIT;
   localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
   localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CntW-1:0]       BlankLast = CntW'(BLANK_CYCLES - 1);
   localparam logic [CntW-1:0]       DriveLast = CntW'(CYCLES_PER_DIGIT - 1);
   localparam logic [IdxW-1:0]       IdxLast   = IdxW'(NUM_DIGITS - 1);
   // Digit-select value with every line inactive.
   localparam logic [NUM_DIGITS-1:0] SelOff    = DIGIT_SEL_ACTIVE_LOW ? '1 : '0;

   scan_state_e             state_q;
   logic [IdxW-1:0]         idx_q;
   logic [CntW-1:0]         cnt_q;
   // Low for the first cycle after reset so the first frame starts one cycle late.
   logic                    run_q;
   // High while the outputs show the last drive cycle of the last digit.
   logic                    bnd_q;

   logic [7:0]              seg_q;
   logic [NUM_DIGITS-1:0]   sel_q;
   logic                    frame_start_q;

   logic [4*NUM_DIGITS-1:0] active_data_q, pend_data_q;
   logic [NUM_DIGITS-1:0]   active_dp_q, pend_dp_q;
   logic [NUM_DIGITS-1:0]   active_blank_q, pend_blank_q;
   logic                    full_q, full_d;
   logic                    wr_ready_q;

   logic [3:0]              nibble;
   logic                    dp_sel;
   logic                    blank_sel;
   logic [NUM_DIGITS-1:0]   sel_on;
   logic [7:0]              hex_seg;
   logic [7:0]              seg_mux;
   logic                    wr_accept;
   logic                    swap;

   // Select the current digit's active fields and its strobe pattern.
   always_comb begin
      nibble    = 4'h0;
      dp_sel    = 1'b0;
      blank_sel = 1'b0;
      sel_on    = '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IdxW'(k)) begin
            nibble    = active_data_q[4*k +: 4];
            dp_sel    = active_dp_q[k];
            blank_sel = active_blank_q[k];
            sel_on[k] = 1'b1;
         end
      end
      sel_on = sel_on ^ SelOff;
   end

   hex_to_7seg u_hex_to_7seg (
      .nibble_i (nibble),
      .seg_o    (hex_seg)
   );

   // Decoder never drives dp, so overwrite that bit with the digit's dp flag.
   always_comb begin
      seg_mux         = hex_seg;
      seg_mux[SEG_DP] = dp_sel;
   end

   // Slot sequencer; outputs are registered from the slot state so segments and
   // strobe always switch on the same edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= StBlank;
         idx_q         <= '0;
         cnt_q         <= '0;
         run_q         <= 1'b0;
         bnd_q         <= 1'b0;
         seg_q         <= '0;
         sel_q         <= SelOff;
         frame_start_q <= 1'b0;
      end else begin
         run_q         <= 1'b1;
         bnd_q         <= 1'b0;
         seg_q         <= '0;
         sel_q         <= SelOff;
         frame_start_q <= 1'b0;
         if (run_q) begin
            unique case (state_q)
               StBlank: begin
                  frame_start_q <= (idx_q == '0) && (cnt_q == '0);
                  if (cnt_q == BlankLast) begin
                     state_q <= StDrive;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               StDrive: begin
                  if (!blank_sel) begin
                     seg_q <= seg_mux;
                     sel_q <= sel_on;
                  end
                  if (cnt_q == DriveLast) begin
                     bnd_q   <= (idx_q == IdxLast);
                     state_q <= StBlank;
                     cnt_q   <= '0;
                     idx_q   <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               default: state_q <= StBlank;
            endcase
         end
      end
   end

   // Accept and swap are exclusive: a swap needs full set, which holds ready low.
   assign wr_accept = i_wr_valid && wr_ready_q;
   assign swap      = bnd_q && full_q;

   always_comb begin
      full_d = full_q;
      if (wr_accept) begin
         full_d = 1'b1;
      end else if (swap) begin
         full_d = 1'b0;
      end
   end

   // Pending/active frame buffers; active only changes at the frame boundary.
   always_ff @(posedge CLK) begin
      if (RST) begin
         active_data_q  <= '0;
         active_dp_q    <= '0;
         active_blank_q <= '0;
         pend_data_q    <= '0;
         pend_dp_q      <= '0;
         pend_blank_q   <= '0;
         full_q         <= 1'b0;
         wr_ready_q     <= 1'b0;
      end else begin
         if (swap) begin
            active_data_q  <= pend_data_q;
            active_dp_q    <= pend_dp_q;
            active_blank_q <= pend_blank_q;
         end
         if (wr_accept) begin
            pend_data_q  <= i_wr_data;
            pend_dp_q    <= i_wr_dp;
            pend_blank_q <= i_wr_blank;
         end
         full_q     <= full_d;
         wr_ready_q <= !full_d;
      end
   end

   assign o_seg         = seg_q;
   assign o_digit_sel   = sel_q;
   assign o_frame_start = frame_start_q;
   assign o_wr_ready    = wr_ready_q;

endmodule
